sdram_apb_arbiter: RTL and testbench
====================================

Name: sdram_apb_arbiter

Overview:
- Two-requester APB arbiter that shares the single APB slave port of the SDRAM APB bridge, e.g. between IFU fetch (m0) and LSU load/store (m1).
- Accepts APB transfers on two upstream slave ports and replays exactly one at a time on one downstream APB master port.
- Returns the downstream response only to the granted requester; the other requester is held in wait states.
- Arbitration is round-robin or fixed-priority, selected by parameter.

Parameters:
- ARB_MODE, 0, 0 = round-robin between m0/m1; 1 = fixed priority, m0 always wins ties.

Ports:
- clock  in  1  Single clock. Every register samples on its posedge.
- reset  in  1  Synchronous, active-high reset, sampled on posedge clock.
- mN_paddr  in  32  Requester N address (N = 0, 1; the same port set exists for each requester).
- mN_psel  in  1  Requester N select.
- mN_penable  in  1  Requester N enable.
- mN_pprot  in  3  Requester N protection bits.
- mN_pwrite  in  1  Requester N write flag.
- mN_pwdata  in  32  Requester N write data.
- mN_pstrb  in  4  Requester N byte strobes.
- mN_pready  out  1  Requester N ready.
- mN_prdata  out  32  Requester N read data.
- mN_pslverr  out  1  Requester N slave error.
- s_paddr, s_psel, s_penable, s_pprot, s_pwrite, s_pwdata, s_pstrb  out  32/1/1/3/1/32/4  Downstream APB request.
- s_pready, s_prdata, s_pslverr  in  1/32/1  Downstream APB response.
- grant  out  2  One-hot owner of the current transfer; 00 when idle. Debug/perf use.

Behaviour:
- Reset values: state IDLE; grant=00; all s_* outputs 0; all mN_pready/prdata/pslverr 0; last_served=1, so m0 wins the first tie.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Request N is valid when mN_psel=1.
  - None valid: stay in IDLE.
  - Otherwise pick a winner:
    - ARB_MODE=1: m0 if valid, else m1.
    - ARB_MODE=0: single valid requester wins; if both are valid, the requester != last_served wins.
  - Latch the winner's paddr/pprot/pwrite/pwdata/pstrb into registers, set grant, go to SETUP.
- SETUP (exactly 1 cycle): s_psel=1, s_penable=0, s_* driven from latched registers. Go to ACCESS.
- ACCESS:
  - s_psel=1, s_penable=1, same latched values.
  - Hold while s_pready=0. No timeout.
  - When s_pready=1:
    - The granted mN_pready=1 in the same cycle (combinational); mN_prdata=s_prdata and mN_pslverr=s_pslverr, valid only in that cycle.
    - last_served<=granted index, grant<=00, go to IDLE.
- Ungranted requester: mN_pready=0, mN_prdata=0, mN_pslverr=0 at all times.
- s_psel/s_penable are 0 in IDLE.
- Latency: requester psel sampled in IDLE at cycle T → s_psel at T+1 → s_penable at T+2. For a zero-wait slave, mN_pready is seen at T+2. Minimum 3 cycles per transfer, no bubble removal.
- Back-to-back: a requester that re-asserts psel the cycle after its pready is seen in IDLE and competes normally. Under round-robin, two continuously requesting masters strictly alternate.
- Requester changes request signals while waiting: ignored. Latched values are used; requesters are required to hold them stable (APB rule).
- Requester drops psel before grant: request vanishes, nothing issued.
- Requester drops psel after grant:
  - The downstream transfer completes anyway.
  - The response is discarded; mN_pready still pulses, but that requester has already left the transfer.
- Simultaneous s_pready with a new request from the other master: the new request is served starting the next IDLE cycle, not in the same cycle.
- Reset asserted mid-transfer: next cycle returns to reset values. The in-flight downstream access is abandoned; the downstream slave is expected to be reset in the same cycle.
- s_pslverr is passed through unmodified; the arbiter generates no errors of its own.

Test Plan:
- Single read, m0 only: m0 read paddr=0xA000_0010; slave returns prdata=0xDEADBEEF after 4 wait cycles → s_psel at T+1, s_penable at T+2, m0_pready at T+6 with m0_prdata=0xDEADBEEF; m1_pready stays 0.
- Write forwarding, m1 only: m1 write pwdata=0x1234_5678, pstrb=0b0011 → s_pwdata/s_pstrb match from SETUP through ACCESS; s_pwrite=1; grant=10.
- Tie, round-robin (ARB_MODE=0, after reset): both request in the same cycle → m0 served first, then m1. Repeated continuous requests alternate m0, m1, m0, m1.
- Tie, fixed priority (ARB_MODE=1): m0 requests continuously and m1 requests once → m1 never granted while m0 keeps psel high; granted on the first IDLE cycle with m0_psel=0.
- Error path: slave returns s_pslverr=1 → only the granted requester sees pslverr=1 with pready=1. The next transfer on the same requester shows pslverr=0.
- Reset mid-ACCESS: assert reset while s_penable=1 → next cycle all outputs 0, grant=00. A post-reset simultaneous request grants m0.

Source files
------------

// File: rtl/sdram_apb_arbiter_if.sv
// -----------------------------------------------------------------------------
// sdram_apb_arbiter_if
//
// One APB link, used both for the upstream requester ports and for the
// downstream port towards the SDRAM APB bridge.
//
// Signals
//   paddr[31:0], psel, penable, pprot[2:0], pwrite, pwdata[31:0], pstrb[3:0]
//       request, driven by the APB master side
//   pready, prdata[31:0], pslverr
//       response, driven by the APB slave side
//
// Modports
//   master : the side that issues transfers
//   slave  : the side that answers them
// -----------------------------------------------------------------------------
interface sdram_apb_arbiter_if;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic [2:0]  pprot;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pprot, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/sdram_apb_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_apb_arbiter
//
// Shares the single APB slave port of the SDRAM APB bridge between two
// requesters (typically IFU fetch on m0 and LSU load/store on m1). One
// upstream transfer at a time is latched and replayed downstream as a plain
// SETUP/ACCESS APB transfer; the response goes back only to the requester
// that owns the transfer, the other one sees wait states.
//
// Parameters
//   ARB_MODE : 0 = round-robin between m0/m1, 1 = fixed priority (m0 wins)
//
// Ports
//   clock : clock, all registers on posedge
//   reset : synchronous active-high reset
//   m0    : requester 0 (slave modport)
//   m1    : requester 1 (slave modport)
//   s     : downstream APB port (master modport)
//   grant : one-hot owner of the current transfer, 00 when idle
// -----------------------------------------------------------------------------
module sdram_apb_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  sdram_apb_arbiter_if.slave         m0,
  sdram_apb_arbiter_if.slave         m1,
  sdram_apb_arbiter_if.master        s,
  output logic [1:0]                 grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_grant;
  logic        r_last;      // index of the requester served most recently

  logic [31:0] r_paddr;
  logic [2:0]  r_pprot;
  logic        r_pwrite;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;

  logic        w_req0;
  logic        w_req1;
  logic        w_any;
  logic        w_pick1;
  logic        w_start;
  logic        w_done;

  // penable from the requesters carries no information for the arbiter:
  // a request is recognised by psel alone.
  logic        w_unused;
  assign w_unused = &{1'b0, m0.penable, m1.penable};

  assign w_req0  = m0.psel;
  assign w_req1  = m1.psel;
  assign w_any   = w_req0 | w_req1;
  assign w_start = (r_state == IDLE) && w_any;
  assign w_done  = (r_state == ACCESS) && s.pready;
  assign grant   = r_grant;

  // Winner selection. In round-robin a tie goes to whoever was not served
  // last; r_last resets to 1 so m0 wins the first tie.
  always_comb begin
    w_pick1 = 1'b0;
    if (ARB_MODE == 1) begin
      w_pick1 = !w_req0 && w_req1;
    end else begin
      w_pick1 = w_req1 && (!w_req0 || !r_last);
    end
  end

  // State, grant and fairness history
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_grant <= 2'b00;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_grant <= w_pick1 ? 2'b10 : 2'b01;
      end else if (w_done) begin
        r_grant <= 2'b00;
        r_last  <= r_grant[1];
      end
    end
  end

  // Request capture. These registers are only observed outside IDLE, so
  // they need no reset.
  always_ff @(posedge clock) begin
    if (w_start) begin
      r_paddr  <= w_pick1 ? m1.paddr  : m0.paddr;
      r_pprot  <= w_pick1 ? m1.pprot  : m0.pprot;
      r_pwrite <= w_pick1 ? m1.pwrite : m0.pwrite;
      r_pwdata <= w_pick1 ? m1.pwdata : m0.pwdata;
      r_pstrb  <= w_pick1 ? m1.pstrb  : m0.pstrb;
    end
  end

  // Next state and all outputs
  always_comb begin
    w_state_nxt = r_state;

    s.psel     = 1'b0;
    s.penable  = 1'b0;
    s.paddr    = '0;
    s.pprot    = '0;
    s.pwrite   = 1'b0;
    s.pwdata   = '0;
    s.pstrb    = '0;

    m0.pready  = 1'b0;
    m0.prdata  = '0;
    m0.pslverr = 1'b0;
    m1.pready  = 1'b0;
    m1.prdata  = '0;
    m1.pslverr = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any) w_state_nxt = SETUP;
      end
      SETUP: begin
        s.psel      = 1'b1;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        s.psel    = 1'b1;
        s.penable = 1'b1;
        if (s.pready) begin
          w_state_nxt = IDLE;
          // Response is steered combinationally to the owner only; it is
          // valid for this single cycle.
          if (r_grant[1]) begin
            m1.pready  = 1'b1;
            m1.prdata  = s.prdata;
            m1.pslverr = s.pslverr;
          end else begin
            m0.pready  = 1'b1;
            m0.prdata  = s.prdata;
            m0.pslverr = s.pslverr;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Downstream request fields are zero whenever no transfer is in flight.
    if (r_state != IDLE) begin
      s.paddr  = r_paddr;
      s.pprot  = r_pprot;
      s.pwrite = r_pwrite;
      s.pwdata = r_pwdata;
      s.pstrb  = r_pstrb;
    end
  end

endmodule

// File: tb/tb_sdram_apb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_apb_arbiter
//
// Two arbiter instances run side by side: index 0 is round-robin, index 1 is
// fixed priority. Each has its own randomized pair of requesters and its own
// random-wait slave. A transaction-level reference model predicts, for every
// cycle, what the downstream port, grant and both upstream responses must
// show, from the arbitration rule and the fixed APB timing (request seen at
// cycle T, psel at T+1, penable from T+2 until the slave answers).
// -----------------------------------------------------------------------------
module tb_sdram_apb_arbiter;

  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Requester side, [instance][requester]
  logic [31:0] m_paddr   [2][2];
  logic        m_psel    [2][2];
  logic        m_penable [2][2];
  logic [2:0]  m_pprot   [2][2];
  logic        m_pwrite  [2][2];
  logic [31:0] m_pwdata  [2][2];
  logic [3:0]  m_pstrb   [2][2];
  wire         m_pready  [2][2];
  wire  [31:0] m_prdata  [2][2];
  wire         m_pslverr [2][2];

  // Downstream side, [instance]
  wire  [31:0] s_paddr   [2];
  wire         s_psel    [2];
  wire         s_penable [2];
  wire  [2:0]  s_pprot   [2];
  wire         s_pwrite  [2];
  wire  [31:0] s_pwdata  [2];
  wire  [3:0]  s_pstrb   [2];
  logic        s_pready  [2];
  logic [31:0] s_prdata  [2];
  logic        s_pslverr [2];
  wire  [1:0]  grant     [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    sdram_apb_arbiter_if m0_if ();
    sdram_apb_arbiter_if m1_if ();
    sdram_apb_arbiter_if s_if ();

    assign m0_if.paddr   = m_paddr[d][0];
    assign m0_if.psel    = m_psel[d][0];
    assign m0_if.penable = m_penable[d][0];
    assign m0_if.pprot   = m_pprot[d][0];
    assign m0_if.pwrite  = m_pwrite[d][0];
    assign m0_if.pwdata  = m_pwdata[d][0];
    assign m0_if.pstrb   = m_pstrb[d][0];
    assign m_pready[d][0]  = m0_if.pready;
    assign m_prdata[d][0]  = m0_if.prdata;
    assign m_pslverr[d][0] = m0_if.pslverr;

    assign m1_if.paddr   = m_paddr[d][1];
    assign m1_if.psel    = m_psel[d][1];
    assign m1_if.penable = m_penable[d][1];
    assign m1_if.pprot   = m_pprot[d][1];
    assign m1_if.pwrite  = m_pwrite[d][1];
    assign m1_if.pwdata  = m_pwdata[d][1];
    assign m1_if.pstrb   = m_pstrb[d][1];
    assign m_pready[d][1]  = m1_if.pready;
    assign m_prdata[d][1]  = m1_if.prdata;
    assign m_pslverr[d][1] = m1_if.pslverr;

    assign s_paddr[d]    = s_if.paddr;
    assign s_psel[d]     = s_if.psel;
    assign s_penable[d]  = s_if.penable;
    assign s_pprot[d]    = s_if.pprot;
    assign s_pwrite[d]   = s_if.pwrite;
    assign s_pwdata[d]   = s_if.pwdata;
    assign s_pstrb[d]    = s_if.pstrb;
    assign s_if.pready   = s_pready[d];
    assign s_if.prdata   = s_prdata[d];
    assign s_if.pslverr  = s_pslverr[d];

    sdram_apb_arbiter #(.ARB_MODE(d)) u_dut (
      .clock (clk),
      .reset (rst),
      .m0    (m0_if.slave),
      .m1    (m1_if.slave),
      .s     (s_if.master),
      .grant (grant[d])
    );
  end

  int n_chk;
  int n_err;

  // Requester bookkeeping
  logic act     [2][2];
  logic saw_rdy [2][2];

  // Reference model, one outstanding transfer per instance
  logic        busy   [2];
  int          owner  [2];
  int          start  [2];
  logic        last   [2];
  logic        fresh  [2];
  logic [31:0] e_paddr  [2];
  logic [2:0]  e_pprot  [2];
  logic        e_pwrite [2];
  logic [31:0] e_pwdata [2];
  logic [3:0]  e_pstrb  [2];
  int          served [2][2];

  logic want_rst;
  logic rst_done;
  logic pen_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic new_txn(input int d, input int n);
    act[d][n]       = 1'b1;
    m_psel[d][n]    = 1'b1;
    m_penable[d][n] = 1'b0;
    m_paddr[d][n]   = $urandom;
    m_pprot[d][n]   = 3'($urandom_range(0, 7));
    m_pwrite[d][n]  = 1'($urandom_range(0, 1));
    m_pwdata[d][n]  = $urandom;
    m_pstrb[d][n]   = 4'($urandom_range(0, 15));
  endtask

  task automatic go_idle(input int d, input int n);
    act[d][n]       = 1'b0;
    m_psel[d][n]    = 1'b0;
    m_penable[d][n] = 1'b0;
    m_paddr[d][n]   = $urandom;
    m_pwdata[d][n]  = $urandom;
  endtask

  task automatic drive_requesters();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        if (act[d][n]) begin
          if (saw_rdy[d][n]) begin
            // back-to-back request on a third of completions
            if ($urandom_range(0, 2) == 0) new_txn(d, n);
            else go_idle(d, n);
          end else if ($urandom_range(0, 39) == 0) begin
            go_idle(d, n);                     // abandon (before or after grant)
          end else begin
            m_penable[d][n] = 1'b1;
            // changed fields only matter if the transfer is not yet granted
            if ($urandom_range(0, 7) == 0) begin
              m_paddr[d][n]  = $urandom;
              m_pwdata[d][n] = $urandom;
            end
          end
        end else if ($urandom_range(0, 1) == 0) begin
          new_txn(d, n);
        end else begin
          go_idle(d, n);
        end
      end
    end
  endtask

  task automatic drive_slaves();
    for (int d = 0; d < 2; d++) begin
      s_pready[d]  = ($urandom_range(0, 2) == 0);
      s_prdata[d]  = $urandom;
      s_pslverr[d] = ($urandom_range(0, 3) == 0);
    end
  endtask

  // One cycle of the reference model for instance d, sampled mid-cycle.
  task automatic step(input int d, input int c);
    string p;
    int    age;
    logic  ready;
    logic  mine;
    p = $sformatf("arb%0d_", d);
    if (!busy[d]) begin
      chk({p, "grant_idle"}, grant[d], 0);
      chk({p, "psel_idle"}, s_psel[d], 0);
      chk({p, "penable_idle"}, s_penable[d], 0);
      if (fresh[d]) begin
        chk({p, "paddr_rst"}, s_paddr[d], 0);
        chk({p, "pwdata_rst"}, s_pwdata[d], 0);
        chk({p, "pstrb_rst"}, s_pstrb[d], 0);
        chk({p, "pprot_rst"}, s_pprot[d], 0);
        chk({p, "pwrite_rst"}, s_pwrite[d], 0);
      end
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("%sm%0d_pready_idle", p, n), m_pready[d][n], 0);
        chk($sformatf("%sm%0d_prdata_idle", p, n), m_prdata[d][n], 0);
        chk($sformatf("%sm%0d_pslverr_idle", p, n), m_pslverr[d][n], 0);
      end
      if (!rst && (m_psel[d][0] || m_psel[d][1])) begin
        if (m_psel[d][0] && m_psel[d][1])
          owner[d] = (d == 1) ? 0 : (last[d] ? 0 : 1);
        else
          owner[d] = m_psel[d][0] ? 0 : 1;
        e_paddr[d]  = m_paddr[d][owner[d]];
        e_pprot[d]  = m_pprot[d][owner[d]];
        e_pwrite[d] = m_pwrite[d][owner[d]];
        e_pwdata[d] = m_pwdata[d][owner[d]];
        e_pstrb[d]  = m_pstrb[d][owner[d]];
        busy[d]  = 1'b1;
        start[d] = c;
        fresh[d] = 1'b0;
      end
    end else begin
      age = c - start[d];
      chk({p, "grant"}, grant[d], (owner[d] == 1) ? 2'b10 : 2'b01);
      chk({p, "psel"}, s_psel[d], 1);
      chk({p, "penable"}, s_penable[d], (age >= 2) ? 1 : 0);
      chk({p, "paddr"}, s_paddr[d], e_paddr[d]);
      chk({p, "pprot"}, s_pprot[d], e_pprot[d]);
      chk({p, "pwrite"}, s_pwrite[d], e_pwrite[d]);
      chk({p, "pwdata"}, s_pwdata[d], e_pwdata[d]);
      chk({p, "pstrb"}, s_pstrb[d], e_pstrb[d]);
      ready = (age >= 2) && s_pready[d];
      for (int n = 0; n < 2; n++) begin
        mine = ready && (owner[d] == n);
        chk($sformatf("%sm%0d_pready", p, n), m_pready[d][n], mine);
        chk($sformatf("%sm%0d_prdata", p, n), m_prdata[d][n], mine ? s_prdata[d] : 32'h0);
        chk($sformatf("%sm%0d_pslverr", p, n), m_pslverr[d][n], mine ? s_pslverr[d] : 1'b0);
      end
      if (ready && !rst) begin
        busy[d] = 1'b0;
        last[d] = (owner[d] == 1);
        served[d][owner[d]]++;
      end
    end
    if (rst) begin
      busy[d]  = 1'b0;
      last[d]  = 1'b1;
      fresh[d] = 1'b1;
    end
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b1;
    want_rst = 1'b0;
    rst_done = 1'b0;
    pen_seen = 1'b0;
    for (int d = 0; d < 2; d++) begin
      busy[d]  = 1'b0;
      owner[d] = 0;
      start[d] = 0;
      last[d]  = 1'b1;
      fresh[d] = 1'b1;
      s_pready[d]  = 1'b0;
      s_prdata[d]  = '0;
      s_pslverr[d] = 1'b0;
      for (int n = 0; n < 2; n++) begin
        saw_rdy[d][n] = 1'b0;
        served[d][n]  = 0;
        go_idle(d, n);
        m_pprot[d][n]  = '0;
        m_pwrite[d][n] = 1'b0;
        m_pstrb[d][n]  = '0;
      end
    end

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      drive_requesters();
      drive_slaves();
      if (c < 4) begin
        rst = 1'b1;
      end else if (rst) begin
        rst = 1'b0;
        // after a mid-run reset both requesters ask at once
        if (c > 4) begin
          for (int d = 0; d < 2; d++) begin
            new_txn(d, 0);
            new_txn(d, 1);
          end
        end
      end else if (want_rst) begin
        // hold the slaves off so instance 0 stays in ACCESS, then reset it
        for (int d = 0; d < 2; d++) s_pready[d] = 1'b0;
        if (pen_seen && c > 2001) begin
          rst      = 1'b1;
          want_rst = 1'b0;
          rst_done = 1'b1;
        end
      end
      if (c == 2000) want_rst = 1'b1;

      @(negedge clk);
      pen_seen = s_penable[0];
      for (int d = 0; d < 2; d++) begin
        for (int n = 0; n < 2; n++) saw_rdy[d][n] = m_pready[d][n];
        step(d, c);
      end
    end

    chk("reset_during_access_reached", rst_done, 1);
    chk("rr_m0_served", (served[0][0] > 0) ? 1 : 0, 1);
    chk("rr_m1_served", (served[0][1] > 0) ? 1 : 0, 1);
    chk("fp_m0_served", (served[1][0] > 0) ? 1 : 0, 1);
    chk("fp_m1_served", (served[1][1] > 0) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
